// File: rtl/i2c_slave_regfile.sv
// I2C slave with a small register bank: write-pointer then data, or read from the current pointer.
// Bus inputs are synchronised and glitch-filtered before any edge or START/STOP detection.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h54,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned FILTER_LEN = 3,
  localparam int unsigned PTR_W     = $clog2(NUM_REGS)
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iSCL,
  input  logic                  iSDA,
  output logic                  oSDA_Oe,
  output logic [NUM_REGS*8-1:0] oRegs,
  output logic                  oWr_Strobe,
  output logic [PTR_W-1:0]      oWr_Index,
  output logic                  oBusy
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRack, StWaitStop
  } state_e;

  logic [1:0]       scl_s_q, sda_s_q;
  logic [CNT_W-1:0] scl_cnt_q, sda_cnt_q;
  logic             scl_f_q, sda_f_q, scl_p_q, sda_p_q;

  // Bus idles high, so the synchroniser and filter reset to 1 to avoid fake edges.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      scl_s_q   <= 2'b11;
      sda_s_q   <= 2'b11;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
    end else begin
      scl_s_q <= {scl_s_q[0], iSCL};
      sda_s_q <= {sda_s_q[0], iSDA};
      if (scl_s_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        scl_f_q   <= scl_s_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end
      if (sda_s_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        sda_f_q   <= sda_s_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  logic scl_rise, scl_fall, bus_start, bus_stop;
  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign bus_start = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign bus_stop  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  state_e           state_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [PTR_W-1:0] ptr_q, wr_idx_q, ptr_inc;
  logic             rw_q, mnack_q, wr_pend_q, sda_oe_q, wr_stb_q, busy_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic             addr_match, ptr_ok;

  assign ptr_inc    = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
  assign addr_match = (shift_q[7:1] == SLAVE_ADDR);
  assign ptr_ok     = ({1'b0, shift_q} < 9'(NUM_REGS));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      wr_idx_q  <= '0;
      rw_q      <= 1'b0;
      mnack_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      // Register write lands one cycle after the 8th data bit is shifted in.
      if (wr_pend_q) begin
        wr_pend_q       <= 1'b0;
        regs_q[ptr_q]   <= shift_q;
        wr_stb_q        <= 1'b1;
        wr_idx_q        <= ptr_q;
        ptr_q           <= ptr_inc;
      end
      if (bus_start) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else if (bus_stop) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StWaitStop: ;
          StAddr, StPtr, StWdata: begin
            if (scl_rise && bit_cnt_q < 4'd8) begin
              shift_q   <= {shift_q[6:0], sda_f_q};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (state_q == StWdata && bit_cnt_q == 4'd7) wr_pend_q <= 1'b1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= '0;
              if (state_q == StAddr) begin
                if (addr_match) begin
                  state_q  <= StAddrAck;
                  sda_oe_q <= 1'b1;
                  rw_q     <= shift_q[0];
                end else begin
                  state_q <= StWaitStop;
                  busy_q  <= 1'b0;
                end
              end else if (state_q == StPtr) begin
                if (ptr_ok) begin
                  state_q  <= StPtrAck;
                  sda_oe_q <= 1'b1;
                  ptr_q    <= shift_q[PTR_W-1:0];
                end else begin
                  state_q <= StWaitStop;
                end
              end else begin
                state_q  <= StWdataAck;
                sda_oe_q <= 1'b1;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (!rw_q) begin
                state_q  <= StPtr;
                sda_oe_q <= 1'b0;
              end else begin
                state_q  <= StRdata;
                shift_q  <= {regs_q[ptr_q][6:0], 1'b0};
                sda_oe_q <= ~regs_q[ptr_q][7];
              end
            end
          end
          StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              state_q   <= StWdata;
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
            end
          end
          StRdata: begin
            if (scl_rise && bit_cnt_q < 4'd8) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              state_q   <= StRack;
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              ptr_q     <= ptr_inc;
            end else if (scl_fall && bit_cnt_q != 4'd0) begin
              sda_oe_q <= ~shift_q[7];
              shift_q  <= {shift_q[6:0], 1'b0};
            end
          end
          StRack: begin
            if (scl_rise) begin
              mnack_q <= sda_f_q;
            end else if (scl_fall) begin
              if (!mnack_q) begin
                state_q   <= StRdata;
                bit_cnt_q <= '0;
                shift_q   <= {regs_q[ptr_q][6:0], 1'b0};
                sda_oe_q  <= ~regs_q[ptr_q][7];
              end else begin
                state_q <= StWaitStop;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs
    assign oRegs[8*g +: 8] = regs_q[g];
  end

  assign oSDA_Oe    = sda_oe_q;
  assign oWr_Strobe = wr_stb_q;
  assign oWr_Index  = wr_idx_q;
  assign oBusy      = busy_q;

endmodule
